// File: rtl/touch_adc_serial_if.sv
// -----------------------------------------------------------------------------
// touch_adc_serial_if
//
// Host-side serial transaction engine for an ADS7843-style touch-panel ADC
// (24 DCLK per conversion). One request runs an X conversion followed by a Y
// conversion in a single chip-select frame (48 DCLK rises) and then delivers
// the coordinate pair.
//
// The ADC_DCLK waveform comes from an external generator: this block only
// drives its ENABLE (DCLK_EN) and watches the resulting level. The generator
// toggles on every CLK while enabled, so one DCLK period is two CLK cycles.
//
// Parameters
//   CMD_X     control byte for the X conversion (sent MSB first)
//   CMD_Y     control byte for the Y conversion (sent MSB first)
//   CS_SETUP  CLK cycles from ADC_CS falling to DCLK_EN rising (1..15)
//
// Ports
//   CLK        system clock
//   RST_n      asynchronous active-low reset
//   START      one-cycle request for a coordinate pair (honoured only when
//              idle and the pen is down)
//   PENIRQ_n   pen-down from the ADC, low = touched (already synchronised)
//   ADC_DCLK   current DCLK level from the generator
//   ADC_DOUT   serial data from the ADC
//   DCLK_EN    enable to the DCLK generator
//   ADC_CS     ADC chip select, active low
//   ADC_DIN    serial command to the ADC
//   X_COORD    last captured X result
//   Y_COORD    last captured Y result
//   NEW_COORD  one-cycle pulse when X_COORD/Y_COORD update
//   BUSY       high while a transaction is in progress
// -----------------------------------------------------------------------------
module touch_adc_serial_if #(
  parameter logic [7:0]  CMD_X    = 8'hD0,
  parameter logic [7:0]  CMD_Y    = 8'h90,
  parameter int unsigned CS_SETUP = 2
) (
  input  logic        CLK,
  input  logic        RST_n,
  input  logic        START,
  input  logic        PENIRQ_n,
  input  logic        ADC_DCLK,
  input  logic        ADC_DOUT,
  output logic        DCLK_EN,
  output logic        ADC_CS,
  output logic        ADC_DIN,
  output logic [11:0] X_COORD,
  output logic [11:0] Y_COORD,
  output logic        NEW_COORD,
  output logic        BUSY
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT,
    S_DONE
  } state_t;

  localparam logic [5:0] RISES_PER_CONV = 6'd24;
  localparam logic [5:0] RISES_TOTAL    = 6'd48;
  localparam logic [5:0] FIRST_DATA_POS = 6'd10;
  localparam logic [5:0] LAST_DATA_POS  = 6'd21;
  localparam logic [3:0] SETUP_LAST     = 4'(CS_SETUP - 1);

  // ---------------------------------------------------------------------------
  // Registers and their next-state values
  // ---------------------------------------------------------------------------
  state_t      r_state,     w_state_nxt;
  logic        r_dclk_q;
  logic [3:0]  r_setup_cnt, w_setup_cnt_nxt;
  logic [5:0]  r_rise_cnt,  w_rise_cnt_nxt;
  logic [11:0] r_shift,     w_shift_nxt;
  logic [11:0] r_x_hold,    w_x_hold_nxt;
  logic        r_dclk_en,   w_dclk_en_nxt;
  logic        r_cs,        w_cs_nxt;
  logic        r_din,       w_din_nxt;
  logic [11:0] r_x_coord,   w_x_coord_nxt;
  logic [11:0] r_y_coord,   w_y_coord_nxt;
  logic        r_new,       w_new_nxt;
  logic        r_busy,      w_busy_nxt;

  // ---------------------------------------------------------------------------
  // DCLK edge detection and position decoding
  // ---------------------------------------------------------------------------
  logic        w_rise;
  logic        w_fall;
  logic [5:0]  w_rise_num;    // 1..48 index of the rise being seen now
  logic [5:0]  w_rise_pos;    // 1..24 position of that rise in its conversion
  logic [5:0]  w_fall_pos;    // 1..24 position of the rise a fall follows
  logic        w_rise_in_y;
  logic        w_fall_in_y;
  logic [7:0]  w_fall_cmd;
  logic [2:0]  w_fall_bit;
  logic [11:0] w_shift_in;

  assign w_rise      = ADC_DCLK & ~r_dclk_q;
  assign w_fall      = ~ADC_DCLK & r_dclk_q;
  assign w_rise_num  = r_rise_cnt + 6'd1;
  assign w_rise_in_y = (w_rise_num > RISES_PER_CONV);
  assign w_fall_in_y = (r_rise_cnt > RISES_PER_CONV);
  assign w_rise_pos  = w_rise_in_y ? (w_rise_num - RISES_PER_CONV) : w_rise_num;
  assign w_fall_pos  = w_fall_in_y ? (r_rise_cnt - RISES_PER_CONV) : r_rise_cnt;
  assign w_fall_cmd  = w_fall_in_y ? CMD_Y : CMD_X;
  // The fall after rise n presents command bit 7-n for the following rise.
  assign w_fall_bit  = 3'd7 - w_fall_pos[2:0];
  assign w_shift_in  = {r_shift[10:0], ADC_DOUT};

  // ---------------------------------------------------------------------------
  // State and register update
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      r_state     <= S_IDLE;
      r_dclk_q    <= 1'b0;
      r_setup_cnt <= '0;
      r_rise_cnt  <= '0;
      r_shift     <= '0;
      r_x_hold    <= '0;
      r_dclk_en   <= 1'b0;
      r_cs        <= 1'b1;
      r_din       <= 1'b0;
      r_x_coord   <= '0;
      r_y_coord   <= '0;
      r_new       <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_dclk_q    <= ADC_DCLK;
      r_setup_cnt <= w_setup_cnt_nxt;
      r_rise_cnt  <= w_rise_cnt_nxt;
      r_shift     <= w_shift_nxt;
      r_x_hold    <= w_x_hold_nxt;
      r_dclk_en   <= w_dclk_en_nxt;
      r_cs        <= w_cs_nxt;
      r_din       <= w_din_nxt;
      r_x_coord   <= w_x_coord_nxt;
      r_y_coord   <= w_y_coord_nxt;
      r_new       <= w_new_nxt;
      r_busy      <= w_busy_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt     = r_state;
    w_setup_cnt_nxt = r_setup_cnt;
    w_rise_cnt_nxt  = r_rise_cnt;
    w_shift_nxt     = r_shift;
    w_x_hold_nxt    = r_x_hold;
    w_dclk_en_nxt   = r_dclk_en;
    w_cs_nxt        = r_cs;
    w_din_nxt       = r_din;
    w_x_coord_nxt   = r_x_coord;
    w_y_coord_nxt   = r_y_coord;
    w_new_nxt       = 1'b0;
    w_busy_nxt      = r_busy;

    unique case (r_state)
      S_IDLE: begin
        if (START && !PENIRQ_n) begin
          w_state_nxt     = S_SETUP;
          w_cs_nxt        = 1'b0;
          w_din_nxt       = CMD_X[7];
          w_busy_nxt      = 1'b1;
          w_rise_cnt_nxt  = '0;
          w_setup_cnt_nxt = '0;
        end
      end

      S_SETUP: begin
        if (r_setup_cnt == SETUP_LAST) begin
          w_setup_cnt_nxt = '0;
          w_dclk_en_nxt   = 1'b1;
          w_state_nxt     = S_SHIFT;
        end else begin
          w_setup_cnt_nxt = r_setup_cnt + 4'd1;
        end
      end

      S_SHIFT: begin
        if (w_rise) begin
          w_rise_cnt_nxt = w_rise_num;
          if (w_rise_pos >= FIRST_DATA_POS && w_rise_pos <= LAST_DATA_POS) begin
            w_shift_nxt = w_shift_in;
            // The X word is complete on its last data rise; keep a copy since
            // the shift register is reused for Y.
            if (w_rise_pos == LAST_DATA_POS && !w_rise_in_y) begin
              w_x_hold_nxt = w_shift_in;
            end
          end
          // Dropping enable on the final rise lets the generator's next toggle
          // bring DCLK low, where it then stays.
          if (w_rise_num == RISES_TOTAL) begin
            w_dclk_en_nxt = 1'b0;
            w_state_nxt   = S_DONE;
          end
        end else if (w_fall) begin
          if (r_rise_cnt == RISES_PER_CONV) begin
            w_din_nxt = CMD_Y[7];
          end else if (w_fall_pos >= 6'd1 && w_fall_pos <= 6'd7) begin
            w_din_nxt = w_fall_cmd[w_fall_bit];
          end else if (w_fall_pos == 6'd8) begin
            w_din_nxt = 1'b0;
          end
        end
      end

      S_DONE: begin
        w_cs_nxt       = 1'b1;
        w_din_nxt      = 1'b0;
        w_x_coord_nxt  = r_x_hold;
        w_y_coord_nxt  = r_shift;
        w_new_nxt      = 1'b1;
        w_busy_nxt     = 1'b0;
        w_rise_cnt_nxt = '0;
        w_state_nxt    = S_IDLE;
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign DCLK_EN   = r_dclk_en;
  assign ADC_CS    = r_cs;
  assign ADC_DIN   = r_din;
  assign X_COORD   = r_x_coord;
  assign Y_COORD   = r_y_coord;
  assign NEW_COORD = r_new;
  assign BUSY      = r_busy;

endmodule

// File: tb/tb_touch_adc_serial_if.sv
// -----------------------------------------------------------------------------
// Testbench for touch_adc_serial_if.
// Contains a DCLK generator, a behavioural ADC (captures the command bytes,
// returns 12-bit words on DOUT) and a scoreboard fed by the stimulus and
// drained by a monitor on NEW_COORD.
// -----------------------------------------------------------------------------
module tb_touch_adc_serial_if;

  localparam logic [7:0]  CMD_X_TB    = 8'hD0;
  localparam logic [7:0]  CMD_Y_TB    = 8'h90;
  localparam int unsigned CS_SETUP_TB = 3;

  logic        CLK = 1'b0;
  logic        RST_n;
  logic        START;
  logic        PENIRQ_n;
  logic        ADC_DCLK;
  logic        ADC_DOUT;
  logic        DCLK_EN;
  logic        ADC_CS;
  logic        ADC_DIN;
  logic [11:0] X_COORD;
  logic [11:0] Y_COORD;
  logic        NEW_COORD;
  logic        BUSY;

  touch_adc_serial_if #(
    .CMD_X   (CMD_X_TB),
    .CMD_Y   (CMD_Y_TB),
    .CS_SETUP(CS_SETUP_TB)
  ) dut (
    .CLK      (CLK),
    .RST_n    (RST_n),
    .START    (START),
    .PENIRQ_n (PENIRQ_n),
    .ADC_DCLK (ADC_DCLK),
    .ADC_DOUT (ADC_DOUT),
    .DCLK_EN  (DCLK_EN),
    .ADC_CS   (ADC_CS),
    .ADC_DIN  (ADC_DIN),
    .X_COORD  (X_COORD),
    .Y_COORD  (Y_COORD),
    .NEW_COORD(NEW_COORD),
    .BUSY     (BUSY)
  );

  always #5 CLK = ~CLK;

  // DCLK generator: toggles every CLK while enabled, otherwise held low.
  always @(posedge CLK or negedge RST_n) begin
    if (!RST_n) ADC_DCLK <= 1'b0;
    else        ADC_DCLK <= DCLK_EN ? ~ADC_DCLK : 1'b0;
  end

  // ---------------------------------------------------------------------------
  // Bookkeeping
  // ---------------------------------------------------------------------------
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  logic [23:0] exp_q[$];
  logic [11:0] adc_x = '0;
  logic [11:0] adc_y = '0;
  int unsigned n_new = 0;
  int unsigned n_exp_new = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // ADC model and monitor, evaluated on the falling CLK edge
  // ---------------------------------------------------------------------------
  logic        m_dclk_prev = 1'b0;
  logic        m_cs_prev   = 1'b1;
  logic        m_new_prev  = 1'b0;
  int unsigned m_rises     = 0;
  int unsigned m_cs_falls  = 0;
  int unsigned m_cs_high_rises = 0;
  int unsigned m_cyc       = 0;
  int unsigned m_t_start   = 0;
  logic [7:0]  m_cmd       = '0;
  logic        m_din_seen  = 1'b0;
  int unsigned pos, nxt;
  logic [11:0] word;
  logic [23:0] e;

  always @(negedge CLK) begin
    m_cyc++;
    if (!RST_n) begin
      m_dclk_prev = 1'b0;
      m_cs_prev   = 1'b1;
      m_new_prev  = 1'b0;
      m_rises     = 0;
      m_cmd       = '0;
      m_din_seen  = 1'b0;
    end else begin
      if (START && !PENIRQ_n && !BUSY) m_t_start = m_cyc;

      if (ADC_CS != m_cs_prev) check("dclk_low_at_cs_edge", 32'(ADC_DCLK), 32'd0);
      if (!ADC_CS && m_cs_prev) begin
        m_rises = 0;
        m_cs_falls++;
      end
      if (ADC_CS && !m_cs_prev) begin
        check("rises_per_frame", m_rises, 32'd48);
        check("dclk_en_off_at_cs_rise", 32'(DCLK_EN), 32'd0);
      end

      if (ADC_DCLK && !m_dclk_prev) begin
        if (ADC_CS) begin
          m_cs_high_rises++;
        end else begin
          m_rises++;
          pos = (m_rises - 1) % 24 + 1;
          if (pos <= 8) begin
            m_cmd = {m_cmd[6:0], ADC_DIN};
            if (pos == 8) begin
              if (m_rises <= 24) check("cmd_x", 32'(m_cmd), 32'(CMD_X_TB));
              else               check("cmd_y", 32'(m_cmd), 32'(CMD_Y_TB));
            end
          end else begin
            m_din_seen = m_din_seen | ADC_DIN;
            if (pos == 24) begin
              check("din_zero_rises_9_24", 32'(m_din_seen), 32'd0);
              m_din_seen = 1'b0;
            end
          end
        end
      end

      // ADC presents the next bit after each falling DCLK; positions outside
      // the data window carry random junk.
      if (!ADC_DCLK && m_dclk_prev && !ADC_CS) begin
        nxt  = m_rises % 24 + 1;
        word = (m_rises < 24) ? adc_x : adc_y;
        if (nxt >= 10 && nxt <= 21) ADC_DOUT = word[21 - nxt];
        else                        ADC_DOUT = 1'($urandom);
      end

      if (m_new_prev) check("new_single_pulse", 32'(NEW_COORD), 32'd0);
      if (NEW_COORD) begin
        n_new++;
        check("new_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("x_coord", 32'(X_COORD), 32'(e[23:12]));
          check("y_coord", 32'(Y_COORD), 32'(e[11:0]));
          check("latency", m_cyc - m_t_start, CS_SETUP_TB + 98);
          check("busy_low_at_new", 32'(BUSY), 32'd0);
          check("cs_high_at_new", 32'(ADC_CS), 32'd1);
        end
      end

      m_new_prev  = NEW_COORD;
      m_dclk_prev = ADC_DCLK;
      m_cs_prev   = ADC_CS;
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  bit jitter_pen = 1'b0;

  task automatic do_read(input logic [11:0] x, input logic [11:0] y);
    @(posedge CLK); #1;
    adc_x = x;
    adc_y = y;
    exp_q.push_back({x, y});
    n_exp_new++;
    START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int unsigned n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(negedge CLK);
      if (jitter_pen) PENIRQ_n = 1'($urandom);
      n++;
    end
    PENIRQ_n = 1'b0;
    check({tag, "_timeout"}, 32'(n < 400), 32'd1);
    if (exp_q.size() != 0) begin
      exp_q.delete();
      n_exp_new = n_new;
    end
    @(posedge CLK); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned falls0;
    int unsigned n;

    RST_n    = 1'b0;
    START    = 1'b0;
    PENIRQ_n = 1'b1;
    ADC_DOUT = 1'b0;

    repeat (3) @(posedge CLK);
    #1;
    check("rst_cs",    32'(ADC_CS),    32'd1);
    check("rst_din",   32'(ADC_DIN),   32'd0);
    check("rst_en",    32'(DCLK_EN),   32'd0);
    check("rst_x",     32'(X_COORD),   32'd0);
    check("rst_y",     32'(Y_COORD),   32'd0);
    check("rst_new",   32'(NEW_COORD), 32'd0);
    check("rst_busy",  32'(BUSY),      32'd0);
    @(negedge CLK); #2;
    RST_n = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    PENIRQ_n = 1'b0;

    // Full read.
    do_read(12'hABC, 12'h123);
    wait_done("full_read");
    repeat (3) @(posedge CLK);
    #1;
    check("post_busy", 32'(BUSY),    32'd0);
    check("post_cs",   32'(ADC_CS),  32'd1);
    check("post_en",   32'(DCLK_EN), 32'd0);
    check("post_din",  32'(ADC_DIN), 32'd0);

    // START with pen up is ignored.
    PENIRQ_n = 1'b1;
    falls0 = m_cs_falls;
    @(posedge CLK); #1; START = 1'b1;
    @(posedge CLK); #1; START = 1'b0;
    repeat (10) @(posedge CLK);
    #1;
    check("penup_no_cs", m_cs_falls, falls0);
    check("penup_busy",  32'(BUSY), 32'd0);
    check("penup_coords_hold", 32'({X_COORD, Y_COORD}), 32'({12'hABC, 12'h123}));
    PENIRQ_n = 1'b0;

    // Second START mid-transaction is dropped.
    do_read(12'h3C5, 12'hA69);
    repeat (20) @(posedge CLK);
    #1; START = 1'b1;
    @(posedge CLK); #1; START = 1'b0;
    wait_done("mid_start");
    repeat (150) @(posedge CLK);
    #1;
    check("mid_start_idle", 32'(BUSY), 32'd0);
    check("mid_start_one_new", n_new, n_exp_new);

    // Reset around rise 30.
    do_read(12'h7E1, 12'h18E);
    n = 0;
    while (m_rises < 30 && n < 400) begin
      @(posedge CLK);
      n++;
    end
    check("reach_rise30", 32'(n < 400), 32'd1);
    #2;
    RST_n = 1'b0;
    exp_q.delete();
    n_exp_new--;
    #1;
    check("abort_cs",   32'(ADC_CS),  32'd1);
    check("abort_en",   32'(DCLK_EN), 32'd0);
    check("abort_busy", 32'(BUSY),    32'd0);
    check("abort_x",    32'(X_COORD), 32'd0);
    check("abort_y",    32'(Y_COORD), 32'd0);
    check("abort_din",  32'(ADC_DIN), 32'd0);
    @(negedge CLK); #2;
    RST_n = 1'b1;
    repeat (2) @(posedge CLK);

    do_read(12'h2D4, 12'hB07);
    wait_done("after_reset");

    // Back-to-back reads with complementary data.
    do_read(12'hFFF, 12'h000);
    wait_done("b2b_1");
    do_read(12'h555, 12'hAAA);
    wait_done("b2b_2");

    // Random data with pen line wiggling during the transaction.
    for (int i = 0; i < 8; i++) begin
      jitter_pen = 1'b0;
      PENIRQ_n   = 1'b0;
      do_read(12'($urandom), 12'($urandom));
      jitter_pen = 1'b1;
      wait_done("random");
      jitter_pen = 1'b0;
      repeat ($urandom_range(0, 4)) @(posedge CLK);
    end

    repeat (10) @(posedge CLK);
    #1;
    check("queue_drained", exp_q.size(), 32'd0);
    check("new_count", n_new, n_exp_new);
    check("no_dclk_while_cs_high", m_cs_high_rises, 32'd0);
    check("final_en", 32'(DCLK_EN), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/touch_adc_serial_if.md
Name: touch_adc_serial_if

Overview:
- Host-side serial transaction engine for the touch-panel ADC (ADS7843-style, 24-clock conversion).
- Drives the ENABLE input of the ADC_DCLK generator and observes the resulting ADC_DCLK level.
- Shifts the control byte out on ADC_DIN and captures 12-bit results from ADC_DOUT.
- Runs one X conversion then one Y conversion per request, and delivers a coordinate pair to the touch controller.

Parameters:
- CMD_X, 8'hD0, control byte for the X-channel conversion (sent MSB first).
- CMD_Y, 8'h90, control byte for the Y-channel conversion (sent MSB first).
- CS_SETUP, 2, CLK cycles between ADC_CS falling and DCLK_EN rising (range 1..15).

Ports:
- CLK  input  1  system clock.
- RST_n  input  1  asynchronous active-low reset.
- START  input  1  one-cycle request to read one coordinate pair.
- PENIRQ_n  input  1  pen-down from the ADC, low = touched; already synchronised.
- ADC_DCLK  input  1  current ADC_DCLK level from the generator.
- ADC_DOUT  input  1  serial data from the ADC.
- DCLK_EN  output  1  ENABLE to the ADC_DCLK generator.
- ADC_CS  output  1  ADC chip select, active low.
- ADC_DIN  output  1  serial command to the ADC.
- X_COORD  output  12  last captured X result.
- Y_COORD  output  12  last captured Y result.
- NEW_COORD  output  1  one-cycle pulse when X_COORD and Y_COORD update.
- BUSY  output  1  high while a transaction is in progress.

Behaviour:
- Clock and reset: single clock, all flops on posedge CLK, asynchronous active-low reset on RST_n.
- Reset values: ADC_CS=1, ADC_DIN=0, DCLK_EN=0, X_COORD=0, Y_COORD=0, NEW_COORD=0, BUSY=0, state IDLE, all counters 0.
- Reset mid-transaction: immediate return to IDLE with the reset values above. The generator (same reset) returns ADC_DCLK to 0.
- Edge detection: register the previous ADC_DCLK as dclk_q.
  - Rise cycle: ADC_DCLK=1 and dclk_q=0.
  - Fall cycle: ADC_DCLK=0 and dclk_q=1.
  - The generator toggles every CLK while enabled, so the DCLK period is 2 CLK.
- State IDLE:
  - START=1 and PENIRQ_n=0: go to SETUP. Set ADC_CS<=0, ADC_DIN<=CMD_X[7], BUSY<=1, clear rise counter (6 bits).
  - START with PENIRQ_n=1 is ignored.
- State SETUP:
  - Count CS_SETUP cycles, then set DCLK_EN<=1 and go to SHIFT.
- State SHIFT: rise counter r increments on each rise cycle, r = 1..48.
  - Conversion phase: r=1..24 is X, r=25..48 is Y. Let n = r mod-24 position (1..24).
  - Command bits: on the fall cycle following rise n (n=1..7), ADC_DIN <= cmd[7-n]. After fall 8, ADC_DIN <= 0 until the next conversion's command.
  - Between conversions: on the fall cycle after rise 24, ADC_DIN <= CMD_Y[7].
  - Data capture: on rise cycles n=10..21, shift ADC_DOUT into a 12-bit register, MSB first. Rises 9 and 22..24 are not sampled.
  - X latch: after rise 21 of the X phase, hold the X result internally.
  - Termination: in the rise cycle r=48, set DCLK_EN<=0 on that same edge so the generator's next toggle returns ADC_DCLK to 0 and it stays low.
  - Then go to DONE.
- State DONE (one cycle):
  - ADC_CS<=1, ADC_DIN<=0, X_COORD/Y_COORD<=captured values, NEW_COORD<=1 for exactly one cycle, BUSY<=0.
  - Next state IDLE.
- START while BUSY=1 is ignored; no queuing.
- PENIRQ_n changes during a transaction are ignored; the ADC drives it unreliably while converting.
- ADC_DCLK is low whenever ADC_CS toggles.
- Exactly 48 rising DCLK edges occur per transaction.
- Latency: START to NEW_COORD = 1 + CS_SETUP + 1 + 96 + 1 CLK cycles, ±1 for edge-alignment. The bench checks the exact count of its own build.
- X_COORD/Y_COORD hold their value until the next NEW_COORD.

Test Plan:
- Full read: PENIRQ_n=0, START pulse, ADC model returns X=12'hABC, Y=12'h123 → NEW_COORD single pulse, X_COORD=12'hABC, Y_COORD=12'h123, BUSY low afterwards, ADC_CS high.
- Command check: the model captures ADC_DIN on the first 8 DCLK rises of each conversion → receives 8'hD0 then 8'h90. ADC_DIN=0 on rises 9..24.
- Clock framing: count DCLK rises while ADC_CS=0 → exactly 48. ADC_DCLK=0 at both ADC_CS edges. DCLK_EN=0 after the transaction.
- Gating: START with PENIRQ_n=1 → no ADC_CS activity, BUSY stays 0. A second START issued mid-transaction → ignored, only one NEW_COORD.
- Reset mid-op: assert RST_n=0 at rise 30 → ADC_CS=1, DCLK_EN=0, BUSY=0, coords=0 immediately. A following full read → correct values.
- Back-to-back: two reads with distinct model data (12'hFFF/12'h000, then 12'h555/12'hAAA) → coords update correctly, no bit carry-over.
